// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues request-to-send, then clocks out a
// byte on device-generated clocks. Optional transaction watchdog under `PS2_TX_TIMEOUT_EN.
module ps2_host_tx #(
  parameter int unsigned CLK_FREQ_HZ = 50000000,
  parameter int unsigned INHIBIT_US  = 100,
  parameter int unsigned TIMEOUT_MS  = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       tx_done,
  output logic       tx_ack_err,
  output logic       tx_timeout
);

  localparam int unsigned InhibitCyc = (CLK_FREQ_HZ / 1000000) * INHIBIT_US;
  localparam int unsigned InhW       = (InhibitCyc > 1) ? $clog2(InhibitCyc) : 1;

  if (InhibitCyc == 0 || TIMEOUT_MS == 0) begin : gen_bad_params
    $error("ps2_host_tx: inhibit and timeout intervals must be non-zero");
  end

  typedef enum logic [2:0] {
    StIdle,
    StInhibit,
    StReq,
    StData,
    StAck,
    StWaitIdle,
    StFinish
  } state_e;

  state_e          state_q;
  logic [1:0]      clk_sync_q;
  logic [1:0]      data_sync_q;
  logic            clk_prev_q;
  logic [7:0]      shift_q;
  logic            parity_q;
  logic [3:0]      bit_cnt_q;
  logic [InhW-1:0] inh_cnt_q;
  logic            ack_err_q;
  logic            fe;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int unsigned TimeoutCyc = TIMEOUT_MS * (CLK_FREQ_HZ / 1000);
  localparam int unsigned TimeoutW   = $clog2(TimeoutCyc + 1);
  logic [TimeoutW-1:0] to_cnt_q;
`endif

  assign fe       = clk_prev_q & ~clk_sync_q[1];
  assign tx_ready = (state_q == StIdle);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_prev_q  <= 1'b1;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      bit_cnt_q   <= '0;
      inh_cnt_q   <= '0;
      ack_err_q   <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      tx_done     <= 1'b0;
      tx_ack_err  <= 1'b0;
      tx_timeout  <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
      to_cnt_q    <= '0;
`endif
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_in};
      data_sync_q <= {data_sync_q[0], ps2_data_in};
      clk_prev_q  <= clk_sync_q[1];
      tx_done     <= 1'b0;
      tx_ack_err  <= 1'b0;
      tx_timeout  <= 1'b0;

      case (state_q)
        StIdle: begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          if (tx_valid) begin
            shift_q    <= tx_data;
            parity_q   <= ~^tx_data;
            bit_cnt_q  <= '0;
            inh_cnt_q  <= '0;
            ps2_clk_oe <= 1'b1;
            state_q    <= StInhibit;
          end
        end
        StInhibit: begin
          // Start bit goes low in the same cycle the clock is released.
          if (inh_cnt_q == InhW'(InhibitCyc - 1)) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b1;
            state_q     <= StReq;
          end else begin
            inh_cnt_q <= inh_cnt_q + 1'b1;
          end
        end
        StReq: state_q <= StData;
        StData: begin
          if (fe) begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q < 4'd8) begin
              ps2_data_oe <= ~shift_q[0];
              shift_q     <= {1'b0, shift_q[7:1]};
            end else if (bit_cnt_q == 4'd8) begin
              ps2_data_oe <= ~parity_q;
            end else begin
              ps2_data_oe <= 1'b0;
              state_q     <= StAck;
            end
          end
        end
        StAck: begin
          if (fe) begin
            ack_err_q <= data_sync_q[1];
            state_q   <= StWaitIdle;
          end
        end
        StWaitIdle: begin
          if (clk_sync_q[1] && data_sync_q[1]) begin
            tx_done    <= ~ack_err_q;
            tx_ack_err <= ack_err_q;
            state_q    <= StFinish;
          end
        end
        // Pulse cycle; ready is only raised once the pulse has been seen.
        StFinish: begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase

`ifdef PS2_TX_TIMEOUT_EN
      if (state_q == StIdle) begin
        to_cnt_q <= '0;
      end else begin
        to_cnt_q <= to_cnt_q + 1'b1;
        if (state_q != StFinish && to_cnt_q == TimeoutW'(TimeoutCyc)) begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          tx_timeout  <= 1'b1;
          state_q     <= StFinish;
        end
      end
`endif
    end
  end

endmodule
